// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the branch resolve unit.
// Predictor state encodings match the 2-bit saturating counter in the predictor.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_state_e;

  localparam int BRU_DEPTH = 4;
  localparam int BRU_AW    = 32;

  // A not-taken branch falls through, so its target is not compared.
  function automatic logic bru_mis(input logic p_taken, input logic r_taken, input logic tgt_eq);
    return (p_taken != r_taken) | (r_taken & ~tgt_eq);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX/predictor-facing signal bundle of the branch resolve unit.
// Stat counters exist only when BRU_STATS_EN is defined.
interface branch_resolve_unit_if #(parameter int AW = 32);
  logic          pred_valid_i;
  logic          pred_ready_o;
  logic          pred_taken_i;
  logic [AW-1:0] pred_target_i;
  logic          res_valid_i;
  logic          res_taken_i;
  logic [AW-1:0] res_target_i;
  logic          ext_flush_i;
  logic          train_valid_o;
  logic          train_taken_o;
  logic          flush_o;
  logic [AW-1:0] redirect_pc_o;
  logic          err_o;
`ifdef BRU_STATS_EN
  logic [31:0]   stat_br_o;
  logic [31:0]   stat_mis_o;
`endif

  modport slave (
`ifdef BRU_STATS_EN
    output stat_br_o, stat_mis_o,
`endif
    input  pred_valid_i, pred_taken_i, pred_target_i,
    input  res_valid_i, res_taken_i, res_target_i, ext_flush_i,
    output pred_ready_o, train_valid_o, train_taken_o, flush_o, redirect_pc_o, err_o
  );

  modport master (
`ifdef BRU_STATS_EN
    input  stat_br_o, stat_mis_o,
`endif
    output pred_valid_i, pred_taken_i, pred_target_i,
    output res_valid_i, res_taken_i, res_target_i, ext_flush_i,
    input  pred_ready_o, train_valid_o, train_taken_o, flush_o, redirect_pc_o, err_o
  );
endinterface

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order FIFO of in-flight predictions; clear wins over push/pop.
// Caller must not push when full or pop when empty.
module bru_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wptr] <= din;
  end

  assign head  = mem[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued fetch predictions with EX outcomes; drives training and mispredict flush.
// Define BRU_STATS_EN to add saturating resolve/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH,
  parameter int AW    = BRU_AW
) (
  input  logic                 clk_i,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);
  logic [AW:0] head;
  logic        full, empty;
  logic        push, res_hit, mis, clear, flush_set;

  // Ready ignores same-cycle pops so it never depends on res_valid_i.
  assign bus.pred_ready_o = ~full;
  assign push      = bus.pred_valid_i & ~full;
  assign res_hit   = bus.res_valid_i & ~empty;
  assign mis       = res_hit & bru_mis(head[AW], bus.res_taken_i,
                                       head[AW-1:0] == bus.res_target_i);
  assign clear     = mis | bus.ext_flush_i;
  assign flush_set = mis & ~bus.ext_flush_i;

  bru_pred_fifo #(.DEPTH(DEPTH), .W(AW+1)) u_fifo (
    .clk_i (clk_i),
    .rst   (rst),
    .push  (push),
    .pop   (res_hit),
    .clear (clear),
    .din   ({bus.pred_taken_i, bus.pred_target_i}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      bus.train_valid_o <= 1'b0;
      bus.train_taken_o <= 1'b0;
      bus.flush_o       <= 1'b0;
      bus.redirect_pc_o <= '0;
      bus.err_o         <= 1'b0;
    end else begin
      bus.train_valid_o <= res_hit;
      bus.flush_o       <= flush_set;
      if (res_hit)   bus.train_taken_o <= bus.res_taken_i;
      if (flush_set) bus.redirect_pc_o <= bus.res_target_i;
      if (bus.res_valid_i && empty) bus.err_o <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      bus.stat_br_o  <= '0;
      bus.stat_mis_o <= '0;
    end else begin
      if (res_hit && bus.stat_br_o != '1)    bus.stat_br_o  <= bus.stat_br_o + 32'd1;
      if (flush_set && bus.stat_mis_o != '1) bus.stat_mis_o <= bus.stat_mis_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against a queue model.
// Define BRU_STATS_EN to also check the stat counters.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.AW(32)) bus();

  branch_resolve_unit #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        t;
    logic [31:0] a;
  } rec_t;

  rec_t        q[$];
  logic        exp_tv = 0, exp_tt = 0, exp_fl = 0, exp_err = 0;
  logic [31:0] exp_pc = 0;
  int unsigned exp_br = 0, exp_mis = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, act, exp);
    end
  endtask

  // Reference: queue of predictions, outputs computed straight from the resolve rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_tv = 0; exp_tt = 0; exp_fl = 0; exp_pc = 0; exp_err = 0;
      exp_br = 0; exp_mis = 0;
    end else begin
      logic had_room, hit, m;
      rec_t h;
      had_room = (q.size() != DEPTH);
      hit = bus.res_valid_i && (q.size() > 0);
      m = 0;
      if (bus.res_valid_i && q.size() == 0) exp_err = 1;
      if (hit) begin
        h = q.pop_front();
        m = (h.t != bus.res_taken_i) || (bus.res_taken_i && h.a != bus.res_target_i);
        exp_tt = bus.res_taken_i;
        if (exp_br != 32'hFFFF_FFFF) exp_br++;
      end
      exp_tv = hit;
      exp_fl = m && !bus.ext_flush_i;
      if (exp_fl) begin
        exp_pc = bus.res_target_i;
        if (exp_mis != 32'hFFFF_FFFF) exp_mis++;
      end
      if (m || bus.ext_flush_i) q.delete();
      else if (bus.pred_valid_i && had_room) q.push_back('{t: bus.pred_taken_i, a: bus.pred_target_i});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", bus.pred_ready_o, (q.size() != DEPTH));
      chk("train_valid", bus.train_valid_o, exp_tv);
      if (exp_tv) chk("train_taken", bus.train_taken_o, exp_tt);
      chk("flush", bus.flush_o, exp_fl);
      chk("redirect_pc", bus.redirect_pc_o, exp_pc);
      chk("err", bus.err_o, exp_err);
`ifdef BRU_STATS_EN
      chk("stat_br", bus.stat_br_o, exp_br);
      chk("stat_mis", bus.stat_mis_o, exp_mis);
`endif
    end
  end

  task automatic cyc(input logic pv, input logic pt, input logic [31:0] pa,
                     input logic rv, input logic rt, input logic [31:0] ra, input logic xf);
    bus.pred_valid_i  = pv;
    bus.pred_taken_i  = pt;
    bus.pred_target_i = pa;
    bus.res_valid_i   = rv;
    bus.res_taken_i   = rt;
    bus.res_target_i  = ra;
    bus.ext_flush_i   = xf;
    @(negedge clk);
  endtask

  task automatic push(input logic t, input logic [31:0] a);
    cyc(1, t, a, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic t, input logic [31:0] a);
    cyc(0, 0, 0, 1, t, a, 0);
  endtask

  initial begin
    bus.pred_valid_i = 0; bus.pred_taken_i = 0; bus.pred_target_i = 0;
    bus.res_valid_i = 0;  bus.res_taken_i = 0;  bus.res_target_i = 0;
    bus.ext_flush_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_train_valid", bus.train_valid_o, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_pc", bus.redirect_pc_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_ready", bus.pred_ready_o, 1);
    rst = 0;
    @(negedge clk);

    // correct prediction
    push(1, 32'h100);
    resolve(1, 32'h100);
    chk("t1_tv", bus.train_valid_o, 1);
    chk("t1_tt", bus.train_taken_o, 1);
    chk("t1_fl", bus.flush_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t1_pulse", bus.train_valid_o, 0);

    // direction miss
    push(0, 32'h104);
    resolve(1, 32'h200);
    chk("t2_tt", bus.train_taken_o, 1);
    chk("t2_fl", bus.flush_o, 1);
    chk("t2_pc", bus.redirect_pc_o, 32'h200);

    // target miss
    push(1, 32'h300);
    resolve(1, 32'h340);
    chk("t3_fl", bus.flush_o, 1);
    chk("t3_pc", bus.redirect_pc_o, 32'h340);

    // fill, then push+pop at full
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_ready_before", bus.pred_ready_o, 1);
      push(1, 32'h400 + 32'(4 * i));
    end
    chk("t4_full", bus.pred_ready_o, 0);
    cyc(1, 1, 32'h999, 1, 1, 32'h400, 0);
    chk("t4_tv", bus.train_valid_o, 1);
    chk("t4_fl", bus.flush_o, 0);
    chk("t4_ready", bus.pred_ready_o, 1);
    for (int i = 1; i < DEPTH; i++) resolve(1, 32'h400 + 32'(4 * i));
    chk("t4_last_fl", bus.flush_o, 0);
    chk("t4_err", bus.err_o, 0);

    // external flush with a same-cycle push
    for (int i = 0; i < 3; i++) push(0, 32'h500 + 32'(4 * i));
    cyc(1, 1, 32'h5FC, 0, 0, 0, 1);
    chk("t5_tv", bus.train_valid_o, 0);
    chk("t5_fl", bus.flush_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t5_ready_before", bus.pred_ready_o, 1);
      push(1, 32'h700 + 32'(4 * i));
    end
    chk("t5_full", bus.pred_ready_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // resolve coinciding with external flush: trains, no flush
    push(0, 32'h600);
    cyc(0, 0, 0, 1, 1, 32'h610, 1);
    chk("tx_tv", bus.train_valid_o, 1);
    chk("tx_tt", bus.train_taken_o, 1);
    chk("tx_fl", bus.flush_o, 0);
    chk("tx_pc", bus.redirect_pc_o, 32'h340);

    // resolve on empty queue
    resolve(1, 32'h10);
    chk("t6_tv", bus.train_valid_o, 0);
    chk("t6_err", bus.err_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t6_err_held", bus.err_o, 1);

    // random traffic with one async reset mid-run
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        bus.pred_valid_i = 1;
        bus.res_valid_i  = 1;
        #2 rst = 1;
        #1;
        chk("arst_tv", bus.train_valid_o, 0);
        chk("arst_fl", bus.flush_o, 0);
        chk("arst_ready", bus.pred_ready_o, 1);
        chk("arst_err", bus.err_o, 0);
        @(negedge clk);
        rst = 0;
      end
      cyc($urandom_range(0, 3) != 0, 1'($urandom), ($urandom % 2) ? 32'h10 : 32'h20,
          $urandom_range(0, 2) == 0, 1'($urandom), ($urandom % 2) ? 32'h10 : 32'h20,
          $urandom_range(0, 15) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
